// File: rtl/btn_pkg.sv
// Shared definitions for the push-button conditioner: FSM encodings and channel indices.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package btn_pkg;

  // Per-channel debounce FSM encodings
  localparam logic [1:0] ST_IDLE         = 2'd0;
  localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
  localparam logic [1:0] ST_HELD         = 2'd2;
  localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE         = ST_IDLE,
    S_PRESS_WAIT   = ST_PRESS_WAIT,
    S_HELD         = ST_HELD,
    S_RELEASE_WAIT = ST_RELEASE_WAIT
  } btn_fsm_e;

  // Bit positions of each button in btn_state and the internal channel vectors
  localparam int CH_U = 2;
  localparam int CH_L = 1;
  localparam int CH_R = 0;

  // Larger of two elaboration-time values, used to size the repeat counter
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchronizer, debounce FSM, optional auto-repeat (BTN_REPEAT_EN).
// Latency: press pulse DEBOUNCE_CYCLES+2 clocks after a clean raw rising edge; release is silent.
// Backpressure: none; pulses are single-cycle strobes that the consumer must take as they come.
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 20000000,
  parameter bit REPEAT_EN       = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic pulse,
  output logic level
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic             sync_q1;
  logic             sync_q2;
  btn_fsm_e         state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             rep_fire;

  // Two-flop synchronizer; nothing downstream ever sees the raw pin
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= raw;
      sync_q2 <= sync_q1;
    end
  end

  // Counter never wraps, so a stuck value can never fake a short stable run
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

`ifdef BTN_REPEAT_EN
  localparam int               REP_W     = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD)) + 1;
  localparam logic [REP_W-1:0] REP_FIRST = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] REP_NEXT  = REP_W'(REPEAT_PERIOD - 1);

  if (REPEAT_EN) begin : g_rep
    logic [REP_W-1:0] rep_cnt;
    logic             rep_first;
    logic             rep_run;
    logic [REP_W-1:0] rep_target;

    // Repeat timing only advances while the debounced button sits in HELD with input high
    assign rep_run    = (state == S_HELD) && sync_q2;
    assign rep_target = rep_first ? REP_FIRST : REP_NEXT;
    assign rep_fire   = rep_run && (rep_cnt == rep_target);

    // Initial delay, then fixed period; restarts whenever HELD is (re)entered
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rep_cnt   <= '0;
        rep_first <= 1'b1;
      end else if (!rep_run) begin
        rep_cnt   <= '0;
        rep_first <= 1'b1;
      end else if (rep_cnt == rep_target) begin
        rep_cnt   <= '0;
        rep_first <= 1'b0;
      end else if (rep_cnt != {REP_W{1'b1}}) begin
        rep_cnt <= rep_cnt + 1'b1;
      end
    end
  end else begin : g_norep
    logic unused_rep;
    assign unused_rep = ^{REP_FIRST, REP_NEXT};
    assign rep_fire   = 1'b0;
  end
`else
  logic unused_rep;
  assign unused_rep = ^{REPEAT_EN, (REPEAT_DELAY > 0), (REPEAT_PERIOD > 0)};
  assign rep_fire   = 1'b0;
`endif

  // Debounce FSM with registered pulse and level outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      pulse <= 1'b0;
      level <= 1'b0;
    end else begin
      pulse <= 1'b0;
      case (state)
        S_IDLE: begin
          if (sync_q2) begin
            state <= S_PRESS_WAIT;
            cnt   <= '0;
          end
        end
        S_PRESS_WAIT: begin
          if (!sync_q2) begin
            // Bounce: drop the candidate press silently
            state <= S_IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= S_HELD;
            cnt   <= '0;
            pulse <= 1'b1;
            level <= 1'b1;
          end else begin
            cnt <= cnt_inc;
          end
        end
        S_HELD: begin
          if (!sync_q2) begin
            state <= S_RELEASE_WAIT;
            cnt   <= '0;
          end else begin
            pulse <= rep_fire;
          end
        end
        S_RELEASE_WAIT: begin
          if (sync_q2) begin
            // Release bounce: back to HELD without a new press pulse
            state <= S_HELD;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= S_IDLE;
            cnt   <= '0;
            level <= 1'b0;
          end else begin
            cnt <= cnt_inc;
          end
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
          level <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Three-button conditioner (U/L/R) with press-pulse arbitration; auto-repeat on L/R under BTN_REPEAT_EN.
// Latency: DEBOUNCE_CYCLES+2 clocks from a clean raw press to its pulse; arbitration adds none.
// Backpressure: none; dUpp overrides L/R, and simultaneous L+R pulses cancel each other.
module button_conditioner
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 20000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       BTNU,
  input  logic       BTNL,
  input  logic       BTNR,
  output logic       dUpp,
  output logic       dLef,
  output logic       dRig,
  output logic [2:0] btn_state
);

  logic [2:0] ch_pulse;
  logic [2:0] ch_level;

  // Up never repeats: it acts as a reset-like command for the LED block
  btn_debounce_ch #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_PERIOD  (REPEAT_PERIOD),
    .REPEAT_EN      (1'b0)
  ) u_ch_u (
    .clk  (clk),
    .rst_n(rst_n),
    .raw  (BTNU),
    .pulse(ch_pulse[CH_U]),
    .level(ch_level[CH_U])
  );

  btn_debounce_ch #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_PERIOD  (REPEAT_PERIOD),
    .REPEAT_EN      (1'b1)
  ) u_ch_l (
    .clk  (clk),
    .rst_n(rst_n),
    .raw  (BTNL),
    .pulse(ch_pulse[CH_L]),
    .level(ch_level[CH_L])
  );

  btn_debounce_ch #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_PERIOD  (REPEAT_PERIOD),
    .REPEAT_EN      (1'b1)
  ) u_ch_r (
    .clk  (clk),
    .rst_n(rst_n),
    .raw  (BTNR),
    .pulse(ch_pulse[CH_R]),
    .level(ch_level[CH_R])
  );

  // Up wins over everything; opposing left/right moves in one cycle cancel out
  assign dUpp      = ch_pulse[CH_U];
  assign dLef      = ch_pulse[CH_L] & ~ch_pulse[CH_U] & ~ch_pulse[CH_R];
  assign dRig      = ch_pulse[CH_R] & ~ch_pulse[CH_U] & ~ch_pulse[CH_L];
  assign btn_state = ch_level;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: run-length reference model checked every cycle plus directed literals.
// Latency: n/a.
// Backpressure: n/a.
module tb_button_conditioner;
  localparam int D  = 4;
  localparam int RD = 8;
  localparam int RP = 3;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       BTNU  = 1'b0;
  logic       BTNL  = 1'b0;
  logic       BTNR  = 1'b0;
  logic       dUpp, dLef, dRig;
  logic [2:0] btn_state;

  int total = 0;
  int bad   = 0;

  button_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .BTNU     (BTNU),
    .BTNL     (BTNL),
    .BTNR     (BTNR),
    .dUpp     (dUpp),
    .dLef     (dLef),
    .dRig     (dRig),
    .btn_state(btn_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A level change is accepted once the synchronized input (raw delayed two
  // clocks) has disagreed with the accepted level for D+1 consecutive samples.
  logic [2:0] h1 = '0, h2 = '0;
  logic [2:0] m_lvl = '0;
  int         m_run[3]  = '{0, 0, 0};
  int         m_hold[3] = '{0, 0, 0};

  function automatic bit rep_on(input int c);
`ifdef BTN_REPEAT_EN
    return (c != 2);
`else
    return (c < 0);
`endif
  endfunction

  function automatic bit rep_due(input int n);
    return (n == RD) || (n > RD && ((n - RD) % RP) == 0);
  endfunction

  always @(posedge clk) begin
    logic [2:0] raw_now, p, e;
    raw_now = {BTNU, BTNL, BTNR};
    p = '0;
    if (!rst_n) begin
      h1 = '0; h2 = '0; m_lvl = '0;
      for (int c = 0; c < 3; c++) begin m_run[c] = 0; m_hold[c] = 0; end
    end else begin
      for (int c = 0; c < 3; c++) begin
        if (h2[c] == m_lvl[c]) begin
          if (m_lvl[c]) begin
            if (m_run[c] > 0) m_hold[c] = 0;
            else begin
              m_hold[c]++;
              if (rep_on(c) && rep_due(m_hold[c])) p[c] = 1'b1;
            end
          end
          m_run[c] = 0;
        end else begin
          m_run[c]++;
          if (m_run[c] == D + 1) begin
            m_lvl[c]  = h2[c];
            m_run[c]  = 0;
            m_hold[c] = 0;
            p[c]      = h2[c];
          end
        end
      end
      h2 = h1;
      h1 = raw_now;
    end
    e = {p[2], p[1] & ~p[2] & ~p[0], p[0] & ~p[2] & ~p[1]};
    #1;
    chk("model_dUpp", dUpp, e[2]);
    chk("model_dLef", dLef, e[1]);
    chk("model_dRig", dRig, e[0]);
    chk("model_btn_state", btn_state, m_lvl);
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input logic rn, input logic [2:0] b, output logic [2:0] po, output logic [2:0] st);
    @(negedge clk);
    rst_n = rn;
    {BTNU, BTNL, BTNR} = b;
    @(posedge clk);
    #2;
    po = {dUpp, dLef, dRig};
    st = btn_state;
  endtask

  task automatic do_reset();
    logic [2:0] po, st;
    for (int i = 0; i < 3; i++) cyc(1'b0, 3'b000, po, st);
    chk("reset_pulses", po, 3'b000);
    chk("reset_state", st, 3'b000);
    for (int i = 0; i < 2; i++) cyc(1'b1, 3'b000, po, st);
  endtask

  initial begin
    logic [2:0] po, st;
    int         n, first, nu;
    int         rq[$];
    int         exp_r[$];
    logic [2:0] lv;
    int         rem[3];
    logic       rn;

    #2 rst_n = 1'b0;
    do_reset();

    // Clean left press at cycle 10, then release at cycle 20
    n = 0; first = -1;
    for (int c = 0; c < 20; c++) begin
      cyc(1'b1, (c >= 10) ? 3'b010 : 3'b000, po, st);
      if (po[1]) begin n++; if (first < 0) first = c; end
      if (c == 15) chk("l_state_before", st, 3'b000);
      if (c == 16) chk("l_state_at16", st, 3'b010);
    end
    chk("l_first_pulse", first, 16);
    chk("l_pulse_count", n, 1);
    n = 0;
    for (int c = 0; c < 8; c++) begin
      cyc(1'b1, 3'b000, po, st);
      if (po != 3'b000) n++;
      if (c == 5) chk("l_release_still_set", st, 3'b010);
      if (c == 6) chk("l_release_cleared", st, 3'b000);
    end
    chk("l_release_no_pulse", n, 0);

    // Right button bouncing every 2 cycles is never accepted
    do_reset();
    n = 0;
    for (int c = 0; c < 20; c++) begin
      cyc(1'b1, (((c / 2) % 2) == 0) ? 3'b001 : 3'b000, po, st);
      if (po[0] || st[0]) n++;
    end
    chk("r_bounce_rejected", n, 0);

    // Up and left together: up wins the pulse, both levels set
    do_reset();
    for (int c = 0; c < 12; c++) begin
      cyc(1'b1, 3'b110, po, st);
      if (c == 5) chk("ul_state_before", st, 3'b000);
      if (c == 6) begin
        chk("ul_pulses_at6", po, 3'b100);
        chk("ul_state_at6", st, 3'b110);
      end
    end
    for (int c = 0; c < 8; c++) cyc(1'b1, 3'b000, po, st);

    // Right held 30 cycles: one pulse, or auto-repeat when enabled
    do_reset();
    rq.delete();
    for (int c = 0; c < 30; c++) begin
      cyc(1'b1, 3'b001, po, st);
      if (po[0]) rq.push_back(c);
    end
`ifdef BTN_REPEAT_EN
    exp_r = '{6, 14, 17, 20, 23, 26, 29};
`else
    exp_r = '{6};
`endif
    chk("r_hold_count", rq.size(), exp_r.size());
    for (int i = 0; i < exp_r.size() && i < rq.size(); i++) chk("r_hold_cycle", rq[i], exp_r[i]);
    for (int c = 0; c < 8; c++) cyc(1'b1, 3'b000, po, st);

    // Up held 30 cycles: always a single pulse at cycle 6
    do_reset();
    nu = 0; first = -1;
    for (int c = 0; c < 30; c++) begin
      cyc(1'b1, 3'b100, po, st);
      if (po[2]) begin nu++; if (first < 0) first = c; end
    end
    chk("u_hold_count", nu, 1);
    chk("u_hold_cycle", first, 6);
    for (int c = 0; c < 8; c++) cyc(1'b1, 3'b000, po, st);

    // Reset during press-wait discards it; re-debounce after release of reset
    do_reset();
    rq.delete();
    for (int c = 0; c < 15; c++) begin
      cyc((c == 3 || c == 4) ? 1'b0 : 1'b1, 3'b010, po, st);
      if (po[1]) rq.push_back(c);
    end
    chk("rst_mid_count", rq.size(), 1);
    if (rq.size() > 0) chk("rst_mid_cycle", rq[0], 11);
    for (int c = 0; c < 8; c++) cyc(1'b1, 3'b000, po, st);

    // Random runs of levels, short bounces and occasional resets
    lv = '0;
    rem = '{0, 0, 0};
    for (int i = 0; i < 4000; i++) begin
      for (int c = 0; c < 3; c++) begin
        if (rem[c] == 0) begin
          lv[c] = ~lv[c];
          rem[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(2, 24));
        end
        rem[c]--;
      end
      rn = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
      cyc(rn, lv, po, st);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
